// File: rtl/tinyalu_pkg.sv
// ---------------------------------------------------------------------------
// tinyalu_pkg
// Shared types and constants for the tinyalu initiator side.
//   op_t        : tinyalu opcodes; any opcode with bit 2 set is a multiply
//   req_state_t : requester FSM states
//   DATA_W      : operand width
//   RES_W       : result width
//   is_mult()   : true for the multi-cycle multiplier opcodes (4..7)
// ---------------------------------------------------------------------------
package tinyalu_pkg;

  localparam int DATA_W = 8;
  localparam int RES_W  = 16;

  typedef enum logic [2:0] {
    NOP = 3'd0,
    ADD = 3'd1,
    AND = 3'd2,
    XOR = 3'd3,
    MUL = 3'd4
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RSP  = 2'd2
  } req_state_t;

  // Opcodes 4..7 all select the multiplier, so only bit 2 matters.
  function automatic logic is_mult(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/tinyalu_requester.sv
// ---------------------------------------------------------------------------
// tinyalu_requester
// Initiator-side controller for the tinyalu start/done handshake. Commands
// arrive on a valid/ready port, are launched on tinyalu with a held start,
// and the captured result is returned on a valid/ready response port. A
// timeout aborts operations whose done never arrives (hung ALU or a NOP
// that slipped through), so the command stream can never deadlock.
//
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready          command handshake (ready only in IDLE)
//   cmd_op, cmd_a, cmd_b         opcode and operands of the command
//   alu_start/op/a/b             drive tinyalu; op/a/b qualified by start
//   alu_done, alu_result         tinyalu completion and result
//   rsp_valid/rsp_ready          response handshake
//   rsp_result, rsp_op           captured result and opcode of the command
//   rsp_timeout                  1 when the operation was aborted
//   busy                         high in any state other than IDLE
// ---------------------------------------------------------------------------
module tinyalu_requester
  import tinyalu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              alu_start,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic              alu_done,
  input  logic [RES_W-1:0]  alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic [2:0]        rsp_op,
  output logic              rsp_timeout,
  output logic              busy
);

  // Last counter value still allowed in WAIT; reaching it without done
  // means start has been high for TIMEOUT_CYCLES cycles.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  req_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                alu_start_q, alu_start_d;
  logic [2:0]          alu_op_q, alu_op_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [RES_W-1:0]    rsp_result_q, rsp_result_d;
  logic [2:0]          rsp_op_q, rsp_op_d;
  logic                rsp_timeout_q, rsp_timeout_d;

  // Next-state logic. Everything holds by default; only the transitions
  // below touch the registers. alu_done is only looked at in WAIT, so a
  // stray or late done in IDLE/RSP has no effect. In WAIT, done is tested
  // before the timeout so it wins when both happen on the same edge.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    alu_start_d   = alu_start_q;
    alu_op_d      = alu_op_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_op_d      = rsp_op_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          alu_op_d = cmd_op;
          alu_a_d  = cmd_a;
          alu_b_d  = cmd_b;
          rsp_op_d = cmd_op;
          if (cmd_op == NOP) begin
            // NOP never reaches the ALU; answer immediately with zero.
            rsp_result_d  = '0;
            rsp_timeout_d = 1'b0;
            rsp_valid_d   = 1'b1;
            state_d       = RSP;
          end else begin
            alu_start_d = 1'b1;
            cnt_d       = '0;
            state_d     = WAIT;
          end
        end
      end
      WAIT: begin
        if (alu_done) begin
          rsp_result_d  = alu_result;
          rsp_timeout_d = 1'b0;
          alu_start_d   = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RSP;
        end else if (cnt_q == TO_LAST) begin
          rsp_result_d  = '0;
          rsp_timeout_d = 1'b1;
          alu_start_d   = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RSP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RSP: begin
        // Start stays low here, which together with the IDLE cycle gives
        // tinyalu's multiplier done chain the two low cycles it needs.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. The asynchronous clear drops alu_start the moment
  // reset_n falls and throws away any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      alu_start_q   <= 1'b0;
      alu_op_q      <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_op_q      <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      alu_start_q   <= alu_start_d;
      alu_op_q      <= alu_op_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_op_q      <= rsp_op_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // cmd_ready is gated by reset_n so every output reads 0 while in reset.
  assign cmd_ready   = (state_q == IDLE) && reset_n;
  assign busy        = (state_q != IDLE);
  assign alu_start   = alu_start_q;
  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_op      = rsp_op_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_tinyalu_requester.sv
// ---------------------------------------------------------------------------
// tb_tinyalu_requester
// Directed bench for tinyalu_requester. A small behavioural tinyalu stand-in
// answers start with done after 1 cycle (ADD/AND/XOR) or 3 cycles (MUL);
// its done can be tied low or forced high to create hangs and stray dones.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_tinyalu_requester;
  import tinyalu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [7:0]  cmd_a = 8'd0;
  logic [7:0]  cmd_b = 8'd0;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_timeout;
  logic        busy;

  int total = 0;
  int bad = 0;

  tinyalu_requester #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_timeout(rsp_timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural tinyalu stand-in
  logic        modelDone = 1'b0;
  logic [15:0] modelRes = 16'd0;
  int          modelCnt = 0;
  logic        tieDoneLow = 1'b0;
  logic        forceDone = 1'b0;

  function automatic logic [15:0] aluCompute(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return 16'd0;
      3'd1: return {8'd0, a} + {8'd0, b};
      3'd2: return {8'd0, a & b};
      3'd3: return {8'd0, a ^ b};
      default: return {8'd0, a} * {8'd0, b};
    endcase
  endfunction

  // Done pulses once after the opcode's latency while start is held
  always @(posedge clk) begin
    if (!alu_start) begin
      modelCnt  <= 0;
      modelDone <= 1'b0;
    end else if (modelDone) begin
      modelDone <= 1'b0;
    end else begin
      if (modelCnt == (is_mult(alu_op) ? 2 : 0)) begin
        modelDone <= 1'b1;
        modelRes  <= aluCompute(alu_op, alu_a, alu_b);
      end
      modelCnt <= modelCnt + 1;
    end
  end

  assign alu_done   = (modelDone & ~tieDoneLow) | forceDone;
  assign alu_result = modelRes;

  // Running monitor: shortest low gap of alu_start between operations,
  // and cmd_ready must be high exactly when the requester is not busy
  int   lowRun = 0;
  int   minLow = 1000;
  bit   seenHigh = 1'b0;
  int   readyViol = 0;
  logic prevStart = 1'b0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (cmd_ready !== !busy) readyViol = readyViol + 1;
      if (alu_start === 1'b1) begin
        if (!prevStart && seenHigh && lowRun < minLow) minLow = lowRun;
        seenHigh = 1'b1;
        lowRun = 0;
      end else begin
        lowRun = lowRun + 1;
      end
      prevStart = alu_start;
    end
  end

  // Presents a command at a falling edge and holds it until accepted; returns
  // at the falling edge one cycle after the handshake
  task automatic sendCmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, output bit ok);
    ok = 1'b0;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Waits (bounded) for rsp_valid, counting falling edges that saw start high
  task automatic waitRsp(output int highs, output bit ok);
    ok = 1'b0;
    highs = 0;
    for (int i = 0; i < 60; i++) begin
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (alu_start === 1'b1) highs++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    total++; if (alu_start !== 1'b0) begin bad++; $display("[TB] FAIL rstStart: got %b expected 0", alu_start); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstRspValid: got %b expected 0", rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rstBusy: got %b expected 0", busy); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("[TB] FAIL rstCmdReady: got %b expected 0", cmd_ready); end
    total++; if (rsp_result !== 16'h0000) begin bad++; $display("[TB] FAIL rstResult: got %h expected 0000", rsp_result); end
    total++; if ({rsp_op, rsp_timeout, alu_op, alu_a, alu_b} !== 23'd0) begin bad++; $display("[TB] FAIL rstRegs: got %h expected 0", {rsp_op, rsp_timeout, alu_op, alu_a, alu_b}); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL idleCmdReady: got %b expected 1", cmd_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL idleBusy: got %b expected 0", busy); end
  endtask

  task automatic test_add();
    bit ok;
    bit seen;
    sendCmd(3'd1, 8'h12, 8'h34, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL addAccept: got %b expected 1", ok); end
    total++; if (alu_start !== 1'b1) begin bad++; $display("[TB] FAIL addStart: got %b expected 1", alu_start); end
    total++; if ({alu_op, alu_a, alu_b} !== {3'd1, 8'h12, 8'h34}) begin bad++; $display("[TB] FAIL addOperands: got %h expected %h", {alu_op, alu_a, alu_b}, {3'd1, 8'h12, 8'h34}); end
    total++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("[TB] FAIL addBusy: got ready=%b busy=%b expected ready=0 busy=1", cmd_ready, busy); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (alu_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL addDoneSeen: got %b expected 1", seen); end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL addRspLatency: got %b expected 1", rsp_valid); end
    total++; if (rsp_result !== 16'h0046) begin bad++; $display("[TB] FAIL addResult: got %h expected 0046", rsp_result); end
    total++; if (rsp_timeout !== 1'b0 || rsp_op !== 3'd1) begin bad++; $display("[TB] FAIL addRspFlags: got to=%b op=%0d expected to=0 op=1", rsp_timeout, rsp_op); end
    total++; if (alu_start !== 1'b0) begin bad++; $display("[TB] FAIL addStartLow: got %b expected 0", alu_start); end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL addRspDone: got valid=%b ready=%b expected valid=0 ready=1", rsp_valid, cmd_ready); end
    total++; if (alu_a !== 8'h12) begin bad++; $display("[TB] FAIL addOperandHold: got %h expected 12", alu_a); end
  endtask

  task automatic test_mul();
    bit ok;
    int highs;
    sendCmd(3'd4, 8'hFF, 8'hFF, ok);
    waitRsp(highs, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL mulRsp: got %b expected 1", ok); end
    total++; if (highs !== 4) begin bad++; $display("[TB] FAIL mulStartCycles: got %0d expected 4", highs); end
    total++; if (rsp_result !== 16'hFE01) begin bad++; $display("[TB] FAIL mulResult: got %h expected FE01", rsp_result); end
    total++; if (rsp_op !== 3'd4 || rsp_timeout !== 1'b0) begin bad++; $display("[TB] FAIL mulRspFlags: got op=%0d to=%b expected op=4 to=0", rsp_op, rsp_timeout); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int highs;
    sendCmd(3'd3, 8'hA5, 8'h0F, ok);
    waitRsp(highs, ok);
    total++; if (ok !== 1'b1 || rsp_result !== 16'h00AA || rsp_op !== 3'd3) begin bad++; $display("[TB] FAIL xorResult: got ok=%b res=%h op=%0d expected ok=1 res=00AA op=3", ok, rsp_result, rsp_op); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("[TB] FAIL rspCmdReady: got %b expected 0", cmd_ready); end
    sendCmd(3'd2, 8'hF0, 8'h3C, ok);
    total++; if (alu_op !== 3'd2) begin bad++; $display("[TB] FAIL andIssued: got op=%0d expected 2", alu_op); end
    waitRsp(highs, ok);
    total++; if (ok !== 1'b1 || rsp_result !== 16'h0030 || rsp_op !== 3'd2) begin bad++; $display("[TB] FAIL andResult: got ok=%b res=%h op=%0d expected ok=1 res=0030 op=2", ok, rsp_result, rsp_op); end
    @(negedge clk);
    total++; if (minLow < 2) begin bad++; $display("[TB] FAIL startLowGap: got %0d expected >=2", minLow); end
    total++; if (readyViol !== 0) begin bad++; $display("[TB] FAIL readyOnlyIdle: got %0d violations expected 0", readyViol); end
  endtask

  task automatic test_nop();
    bit ok;
    sendCmd(3'd0, 8'h55, 8'h66, ok);
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL nopRspLatency: got %b expected 1", rsp_valid); end
    total++; if (rsp_result !== 16'h0000 || rsp_timeout !== 1'b0 || rsp_op !== 3'd0) begin bad++; $display("[TB] FAIL nopRsp: got res=%h to=%b op=%0d expected 0000/0/0", rsp_result, rsp_timeout, rsp_op); end
    total++; if (alu_start !== 1'b0) begin bad++; $display("[TB] FAIL nopStart: got %b expected 0", alu_start); end
    @(negedge clk);
    total++; if (alu_start !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL nopAfter: got start=%b valid=%b expected 0/0", alu_start, rsp_valid); end
  endtask

  task automatic test_timeout();
    bit ok;
    int highs;
    tieDoneLow = 1'b1;
    sendCmd(3'd1, 8'h10, 8'h20, ok);
    waitRsp(highs, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL toRsp: got %b expected 1", ok); end
    total++; if (highs !== 16) begin bad++; $display("[TB] FAIL toStartCycles: got %0d expected 16", highs); end
    total++; if (rsp_timeout !== 1'b1 || rsp_result !== 16'h0000) begin bad++; $display("[TB] FAIL toFlags: got to=%b res=%h expected 1/0000", rsp_timeout, rsp_result); end
    @(negedge clk);
    forceDone = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL lateDone: got valid=%b busy=%b expected 0/0", rsp_valid, busy); end
    end
    forceDone = 1'b0;
    tieDoneLow = 1'b0;
    sendCmd(3'd1, 8'h02, 8'h03, ok);
    waitRsp(highs, ok);
    total++; if (ok !== 1'b1 || rsp_result !== 16'h0005 || rsp_timeout !== 1'b0) begin bad++; $display("[TB] FAIL afterTimeout: got ok=%b res=%h to=%b expected 1/0005/0", ok, rsp_result, rsp_timeout); end
    @(negedge clk);
  endtask

  task automatic test_rsp_hold();
    bit ok;
    int highs;
    rsp_ready = 1'b0;
    sendCmd(3'd4, 8'h03, 8'h05, ok);
    waitRsp(highs, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL holdRsp: got %b expected 1", ok); end
    for (int i = 0; i < 5; i++) begin
      total++; if (rsp_valid !== 1'b1 || rsp_result !== 16'h000F || cmd_ready !== 1'b0) begin bad++; $display("[TB] FAIL holdStable: got valid=%b res=%h ready=%b expected 1/000F/0", rsp_valid, rsp_result, cmd_ready); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL holdRelease: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int highs;
    sendCmd(3'd5, 8'h07, 8'h07, ok);
    total++; if (alu_start !== 1'b1) begin bad++; $display("[TB] FAIL midStart: got %b expected 1", alu_start); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (alu_start !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL asyncReset: got start=%b busy=%b valid=%b expected 0/0/0", alu_start, busy, rsp_valid); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    sendCmd(3'd1, 8'h01, 8'h01, ok);
    waitRsp(highs, ok);
    total++; if (ok !== 1'b1 || rsp_result !== 16'h0002 || rsp_timeout !== 1'b0) begin bad++; $display("[TB] FAIL addAfterReset: got ok=%b res=%h to=%b expected 1/0002/0", ok, rsp_result, rsp_timeout); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_back_to_back();
    test_nop();
    test_timeout();
    test_rsp_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tinyalu_requester.md
Name: tinyalu_requester

Overview:
Initiator-side controller for the tinyalu start/done handshake. It accepts operand/opcode commands on a valid/ready input and drives tinyalu's A/B/op/start. It waits for done, captures result, and presents it on a valid/ready response port. It also supplies a timeout so that a hung or NOP operation never deadlocks the command stream.

Parameters:
TIMEOUT_CYCLES, 16, maximum cycles start may stay high without done before the operation is aborted (legal range 2..255).
CNT_W, 8, width of the internal timeout counter; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  requester can accept a command
cmd_op  in  3  opcode: 0 NOP, 1 ADD, 2 AND, 3 XOR, 4-7 MUL
cmd_a  in  8  operand A
cmd_b  in  8  operand B
alu_start  out  1  tinyalu start
alu_op  out  3  tinyalu op
alu_a  out  8  tinyalu A
alu_b  out  8  tinyalu B
alu_done  in  1  tinyalu done
alu_result  in  16  tinyalu result
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  16  captured result
rsp_op  out  3  opcode of the completed command
rsp_timeout  out  1  1 = operation aborted by timeout
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (reset_n).
- Reset: all outputs, registers and the counter clear to 0; state = IDLE. This applies immediately on assertion, including mid-operation: alu_start drops asynchronously and any in-flight result is discarded.
- States: IDLE, WAIT, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, register op/a/b into alu_op/alu_a/alu_b and rsp_op.
  - If op!=0: alu_start=1 from the next cycle; go to WAIT; counter=0.
  - If op==0 (NOP): no start pulse; rsp_result=0, rsp_timeout=0, rsp_valid=1; go to RSP.
- WAIT:
  - alu_start, alu_op, alu_a and alu_b are held stable; cmd_ready=0.
  - Counter increments each cycle.
  - On a rising edge with alu_done=1: rsp_result<=alu_result, rsp_timeout<=0, alu_start<=0, rsp_valid<=1; go to RSP.
  - Else if counter==TIMEOUT_CYCLES-1: rsp_result<=0, rsp_timeout<=1, alu_start<=0, rsp_valid<=1; go to RSP.
  - If done and timeout coincide, done wins.
- RSP:
  - rsp_valid=1; outputs are held until rsp_ready=1.
  - On handshake: rsp_valid<=0; go to IDLE.
  - alu_start is low throughout RSP. This guarantees at least 2 low cycles between operations, which tinyalu's multiplier done chain requires.
- Stray alu_done outside WAIT (e.g. late done after a timeout) is ignored.
- Latency:
  - alu_start rises 1 cycle after the command handshake.
  - rsp_valid rises 1 cycle after alu_done is sampled high.
  - NOP: rsp_valid 1 cycle after the handshake.
- Throughput: minimum 3 cycles per command beyond the ALU latency (IDLE, WAIT≥1, RSP).
- No command buffering: cmd_ready is high only in IDLE.
- alu_op/alu_a/alu_b keep their last value after completion; only alu_start qualifies them.

Decomposition:
- Shared package tinyalu_pkg:
  - op_t enum (NOP=0, ADD=1, AND=2, XOR=3, MUL=4)
  - function is_mult(op) = op[2]
  - DATA_W=8, RES_W=16
  - req_state_t enum (IDLE, WAIT, RSP)
- No sub-module: the timeout counter and FSM are small enough to live inline. The bench instantiates tinyalu_requester connected to tinyalu as the DUT pair.

Test Plan:
- ADD 8'h12+8'h34 with rsp_ready=1 -> one alu_start pulse sequence, rsp_result=16'h0046, rsp_timeout=0, rsp_valid 1 cycle after alu_done.
- MUL 8'hFF*8'hFF -> alu_start held high until done (~4 cycles); rsp_result=16'hFE01, rsp_op=3'd4; alu_start low ≥2 cycles before the next op.
- Back-to-back XOR A5^0F then AND F0&3C -> rsp 16'h00AA then 16'h0030; cmd_ready only in IDLE; ops issued in order.
- NOP command -> alu_start never asserts; rsp_result=0, rsp_timeout=0 one cycle after the handshake.
- alu_done tied 0, ADD, TIMEOUT_CYCLES=16 -> alu_start high exactly 16 cycles, then rsp_timeout=1, rsp_result=0. A forced late alu_done is ignored, and the next command completes normally.
- Hold rsp_ready=0 for 5 cycles after MUL 3*5 -> rsp_valid and rsp_result=16'h000F stable, cmd_ready=0. Separately, reset_n pulse mid-MUL WAIT -> alu_start=0 asynchronously, busy=0, and a subsequent ADD 1+1 returns 16'h0002.
